riv_async_fifo_wr_arb: RTL

Round-robin arbiter that shares the single write port of an async FIFO among NUM_REQ packet sources. Packets are atomic: once a requester is granted, it owns the port until its last beat is accepted. The block sits in the write clock domain, directly in front of the FIFO write interface. It gates every beat on the FIFO full flag and keeps a completed-packet count for status.

---
 rtl/riv_async_fifo_arb_pkg.sv | 16 +
 rtl/riv_rr_pick.sv | 30 +++
 rtl/riv_async_fifo_wr_arb.sv | 94 +++++++++
 3 files changed

// File: rtl/riv_async_fifo_arb_pkg.sv
// Shared types and helpers for the async-FIFO write-port arbiter.
package riv_async_fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    UNKNOWN_2 = 2'd2,
    UNKNOWN_3 = 2'd3
  } fsm_t;

  // Wrap-around increment of a requester index in the range 0..n-1.
  function automatic logic [31:0] idx_inc(input logic [31:0] idx, input logic [31:0] n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/riv_rr_pick.sv
// Rotating-priority picker: the first set request at or above start_i, wrapping at N.
module riv_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] cand;

  // Scan from the farthest offset down so the nearest hit to start_i is the last write.
  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, start_i} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) begin
        cand = cand - (IW + 1)'(N);
      end
      if (req_i[cand[IW-1:0]]) begin
        idx_o = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/riv_async_fifo_wr_arb.sv
// Round-robin, packet-atomic arbiter sharing one async-FIFO write port among NUM_REQ sources.
module riv_async_fifo_wr_arb
  import riv_async_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data,
  output logic [IW-1:0]                 grant_idx,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          pkt_cnt,
  output logic [1:0]                    dbg_state
);

  // Handshake: a beat moves when req_valid[i] & req_ready[i] in the same cycle; ready is
  // only ever raised for the current owner and never depends on that owner's valid.

  fsm_t                 state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic                 beat_acc;

  riv_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    pkt_cnt_d  = pkt_cnt_q;
    req_ready  = '0;
    beat_acc   = 1'b0;
    busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && pick_found) begin
          grant_d = pick_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        busy               = 1'b1;
        req_ready[grant_q] = ~fifo_full;
        beat_acc           = req_valid[grant_q] & ~fifo_full;
        if (beat_acc && req_last[grant_q]) begin
          state_d   = IDLE;
          rr_ptr_d  = IW'(idx_inc(32'(grant_q), 32'(NUM_REQ)));
          pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write path is purely combinational so fifo_full gates the strobe in the same cycle.
  assign fifo_wr_en   = beat_acc;
  assign fifo_wr_data = req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign grant_idx    = grant_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign dbg_state    = state_q;

endmodule
